// File: rtl/comparator_pkg.sv
// Shared types for the registered magnitude comparator.
// Result encoding and its one-hot {gt, lt, eq} flag mapping.
package comparator_pkg;

  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_LT = 2'd1,
    CMP_GT = 2'd2
  } cmp_result_t;

  function automatic logic [2:0] to_flags(input cmp_result_t res);
    logic [2:0] flags;
    flags = 3'b001;
    case (res)
      CMP_EQ:  flags = 3'b001;
      CMP_LT:  flags = 3'b010;
      CMP_GT:  flags = 3'b100;
      default: flags = 3'b001;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/comparator_core.sv
// Combinational compare of a against b with optional two's-complement handling.
// Equal operands defer to the cascade inputs with priority gt > lt > eq.
module comparator_core
  import comparator_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             casc_eq,
  input  logic             casc_lt,
  input  logic             casc_gt,
  output cmp_result_t      result
);

  logic [WIDTH-1:0] a_m;
  logic [WIDTH-1:0] b_m;
  cmp_result_t      casc_res;

  // Flipping both MSBs maps two's-complement order onto unsigned order.
  always_comb begin
    a_m = a;
    b_m = b;
    if (SIGNED) begin
      a_m[WIDTH-1] = ~a[WIDTH-1];
      b_m[WIDTH-1] = ~b[WIDTH-1];
    end
  end

  // Illegal cascade combinations still resolve to a single result.
  always_comb begin
    casc_res = CMP_EQ;
    casez ({casc_gt, casc_lt, casc_eq})
      3'b1??:  casc_res = CMP_GT;
      3'b01?:  casc_res = CMP_LT;
      3'b001:  casc_res = CMP_EQ;
      default: casc_res = CMP_EQ;
    endcase
  end

  always_comb begin
    result = casc_res;
    if (a_m > b_m) begin
      result = CMP_GT;
    end else if (a_m < b_m) begin
      result = CMP_LT;
    end
  end

endmodule

// File: rtl/comparator.sv
// Registered comparator: flags update one clock after in_valid, hold otherwise.
// No backpressure; full throughput; async reset clears flags and out_valid.
module comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             casc_eq,
  input  logic             casc_lt,
  input  logic             casc_gt,
  output logic             a_e_b,
  output logic             a_l_b,
  output logic             a_g_b,
  output logic             out_valid
);

  cmp_result_t result;
  logic [2:0]  flags;

  comparator_core #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_core (
    .a       (a_in),
    .b       (b_in),
    .casc_eq (casc_eq),
    .casc_lt (casc_lt),
    .casc_gt (casc_gt),
    .result  (result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags     <= 3'b000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        flags <= to_flags(result);
      end
    end
  end

  assign a_g_b = flags[2];
  assign a_l_b = flags[1];
  assign a_e_b = flags[0];

endmodule

// File: tb/tb_comparator.sv
// Scoreboard bench: 1-bit unsigned, 8-bit unsigned and 8-bit signed comparators.
module tb_comparator;

  localparam logic [2:0] E = 3'b001;
  localparam logic [2:0] L = 3'b010;
  localparam logic [2:0] G = 3'b100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v1 = 1'b0;
  logic       v8 = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       ce = 1'b1;
  logic       cl = 1'b0;
  logic       cg = 1'b0;

  logic [2:0] flg [3];
  logic       ov  [3];

  logic [2:0] exp_q [3][$];
  logic [2:0] last  [3];
  string      nm    [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  comparator #(.WIDTH(1), .SIGNED(1'b0)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a_in(a[0:0]), .b_in(b[0:0]),
    .casc_eq(ce), .casc_lt(cl), .casc_gt(cg),
    .a_e_b(flg[0][0]), .a_l_b(flg[0][1]), .a_g_b(flg[0][2]), .out_valid(ov[0]));

  comparator #(.WIDTH(8), .SIGNED(1'b0)) du (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a_in(a), .b_in(b),
    .casc_eq(ce), .casc_lt(cl), .casc_gt(cg),
    .a_e_b(flg[1][0]), .a_l_b(flg[1][1]), .a_g_b(flg[1][2]), .out_valid(ov[1]));

  comparator #(.WIDTH(8), .SIGNED(1'b1)) ds (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a_in(a), .b_in(b),
    .casc_eq(ce), .casc_lt(cl), .casc_gt(cg),
    .a_e_b(flg[2][0]), .a_l_b(flg[2][1]), .a_g_b(flg[2][2]), .out_valid(ov[2]));

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got={ov,g,l,e}=%b want=%b at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: pop on every out_valid; when idle the flags must hold the last result.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        last[k] = 3'b000;
      end else if (ov[k]) begin
        if (exp_q[k].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL %s_unexpected got=%b want=no_output at %0t", nm[k], flg[k], $time);
        end else begin
          last[k] = exp_q[k].pop_front();
          chk({nm[k], "_result"}, {ov[k], flg[k]}, {1'b1, last[k]});
        end
      end else begin
        chk({nm[k], "_hold"}, {ov[k], flg[k]}, {1'b0, last[k]});
      end
    end
  end

  task automatic issue1(input logic av, input logic bv, input logic [2:0] casc, input logic [2:0] e1);
    a = {7'b0, av}; b = {7'b0, bv};
    {cg, cl, ce} = casc;
    v1 = 1'b1; v8 = 1'b0;
    exp_q[0].push_back(e1);
    @(posedge clk); #1;
  endtask

  task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] casc,
                        input logic [2:0] eu, input logic [2:0] es);
    a = av; b = bv;
    {cg, cl, ce} = casc;
    v1 = 1'b0; v8 = 1'b1;
    exp_q[1].push_back(eu);
    exp_q[2].push_back(es);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    v1 = 1'b0; v8 = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    nm[0] = "w1"; nm[1] = "w8u"; nm[2] = "w8s";
    for (int k = 0; k < 3; k++) last[k] = 3'b000;

    #2;
    for (int k = 0; k < 3; k++) chk({nm[k], "_reset"}, {ov[k], flg[k]}, 4'b0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // 1-bit truth table, back-to-back, cascade tied to equal ({gt,lt,eq})
    issue1(1'b0, 1'b0, 3'b001, E);
    issue1(1'b0, 1'b1, 3'b001, L);
    issue1(1'b1, 1'b0, 3'b001, G);
    issue1(1'b1, 1'b1, 3'b001, E);
    idle(3);

    issue8(8'h80, 8'h7F, 3'b001, G, L);
    issue8(8'h00, 8'hFF, 3'b001, L, G);
    issue8(8'hFF, 8'h00, 3'b001, G, L);
    issue8(8'h7F, 8'h7F, 3'b001, E, E);
    issue8(8'h05, 8'h05, 3'b010, L, L);
    issue8(8'h05, 8'h05, 3'b110, G, G);
    issue8(8'h05, 8'h05, 3'b000, E, E);
    issue8(8'h03, 8'h05, 3'b100, L, L);
    issue8(8'hFE, 8'hFF, 3'b001, L, L);
    idle(3);

    // In-flight result lost to an async reset asserted between edges
    a = 8'h01; b = 8'h00; {cg, cl, ce} = 3'b001; v1 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk({nm[k], "_async_reset"}, {ov[k], flg[k]}, 4'b0000);
    @(posedge clk); #1;
    v1 = 1'b0;
    rst_n = 1'b1;
    issue1(1'b0, 1'b1, 3'b001, L);
    issue8(8'h10, 8'h20, 3'b001, L, L);
    idle(3);

    for (int k = 0; k < 3; k++) chk({nm[k], "_queue_empty"}, exp_q[k].size() == 0 ? 4'd0 : 4'd1, 4'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule

// File: doc/comparator.md
# comparator

Registered magnitude comparator for two WIDTH-bit operands. Produces one-hot equal/less/greater flags one clock after a valid input, with optional signed interpretation and 74x85-style cascade inputs so wider compares can be built from chained slices. It sits in datapath compare/branch logic. The default configuration is a 1-bit unsigned compare.

## Interface
Parameters:
- WIDTH, 1, operand width in bits (≥1).
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands and cascade inputs are valid this cycle.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- casc_eq  input  1  lower-slice result "equal"; tie to 1 when unused.
- casc_lt  input  1  lower-slice result "A<B"; tie to 0 when unused.
- casc_gt  input  1  lower-slice result "A>B"; tie to 0 when unused.
- a_e_b  output  1  A == B.
- a_l_b  output  1  A < B.
- a_g_b  output  1  A > B.
- out_valid  output  1  result flags updated this cycle.

## Operation
- Magnitude: unsigned compare when SIGNED=0. When SIGNED=1, both operands are signed; MSB=1 is negative.
- If a_in != b_in, the result comes from the magnitude compare and the cascade inputs are ignored.
- If a_in == b_in, the result is taken from the cascade inputs, with priority casc_gt > casc_lt > casc_eq.
  - If none of the cascade inputs is set, the result is equal.
  - This ensures an illegal cascade combination never produces a non-one-hot output.
- Outputs are always exactly one-hot after the first valid result. Before that, all three flags are 0.
- Default 1-bit truth table:
  - (0,0) → e
  - (0,1) → l
  - (1,0) → g
  - (1,1) → e

## Timing
- Latency: 1 cycle. Inputs sampled at posedge when in_valid=1 appear on the flags at that edge; out_valid=1 for that one cycle.
- in_valid=0: flags hold their last value; out_valid=0.
- Back-to-back valids are allowed: full throughput, one result per cycle, no backpressure.
- Reset (rst_n=0, asynchronous):
  - a_e_b, a_l_b, a_g_b and out_valid go to 0 immediately, independent of clk.
  - Release is synchronous to the next clk edge, i.e. the first edge with rst_n=1 may capture.
  - Reset asserted mid-stream discards the in-flight result.
- There are no combinational paths from inputs to outputs.

## Structure
- Package comparator_pkg:
  - enum cmp_result_t {CMP_EQ, CMP_LT, CMP_GT}.
  - function to_flags(cmp_result_t), returning the 3-bit one-hot {gt, lt, eq}.
- Sub-module comparator_core:
  - Purely combinational.
  - Parameterised by WIDTH and SIGNED.
  - Takes a, b and the cascade inputs; returns cmp_result_t.
  - Implements sign handling and cascade priority.
- Top level comparator: the capture register, valid flop, and async reset.

## Test plan
- 1-bit exhaustive, cascade tied (eq=1): (0,0)→e=1 l=0 g=0; (0,1)→l=1; (1,0)→g=1; (1,1)→e=1. Each result appears 1 cycle after in_valid, with out_valid pulsing once.
- WIDTH=8 unsigned: 8'h80 vs 8'h7F → g=1. WIDTH=8 SIGNED=1, same operands → l=1. Boundary operands 0 vs 8'hFF: unsigned → l=1; signed → g=1.
- Cascade, equal operands:
  - casc_lt=1 → l=1.
  - casc_gt=1 and casc_lt=1 → g=1 (priority).
  - All cascade inputs 0 → e=1.
- Cascade with unequal operands: a=3, b=5, casc_gt=1 → l=1 (cascade ignored).
- Hold and throughput:
  - Four back-to-back valid pairs yield four consecutive correct results.
  - Then in_valid=0 for 3 cycles: flags unchanged, out_valid=0.
- Async reset: assert rst_n=0 between clock edges → all outputs 0 immediately. In-flight result is lost; the first valid after release produces a correct result 1 cycle later.
